// File: rtl/regfile_sb_pkg.sv
// Shared RV32I register-file constants for regfile_sb and its scoreboard.
package regfile_sb_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;
  localparam logic [REG_AW_DEF-1:0] REG_ZERO = 5'd0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: a bit is set on issue and cleared on writeback.
// If both hit the same register in one cycle, the set wins. Register 0 is never busy.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_q;

  // Clear is applied first so that a same-register set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_addr != '0)) busy_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// RV32I integer register file with NUM_RD synchronous read ports, one write port
// and a busy scoreboard. Define REGFILE_BYPASS_EN for write-first reads.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NUM_RD = NUM_RD_DEF,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  input  logic [NUM_RD-1:0]      rs_en,
  output logic [NUM_RD*XLEN-1:0] rv,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   we,
  input  logic [AW-1:0]          rd,
  input  logic [XLEN-1:0]        indata,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  output logic [NREGS-1:0]       busy_vec
);

  logic [XLEN-1:0] mem_d [NREGS];
  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_ok;

  assign wr_ok = we && (rd != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[rd] = indata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_en),
    .set_addr (issue_rd),
    .clr_en   (we),
    .clr_addr (rd),
    .busy_vec (busy_vec)
  );

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rv_d;
    logic [XLEN-1:0] rv_q;

    assign addr = rs_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    logic wr_hit;
    assign wr_hit = wr_ok && (rd == addr);

    // A same-cycle writeback retires the producer unless it is re-issued.
    assign rs_busy[k] = busy_vec[addr] & ~(wr_hit & ~(issue_en && (issue_rd == addr)));

    always_comb begin
      rv_d = rv_q;
      if (rs_en[k]) begin
        if (addr == '0)  rv_d = '0;
        else if (wr_hit) rv_d = indata;
        else             rv_d = mem_q[addr];
      end
    end
`else
    assign rs_busy[k] = busy_vec[addr];

    always_comb begin
      rv_d = rv_q;
      if (rs_en[k]) begin
        if (addr == '0) rv_d = '0;
        else            rv_d = mem_q[addr];
      end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rv_q <= '0;
      else     rv_q <= rv_d;
    end

    assign rv[k*XLEN +: XLEN] = rv_q;
  end : g_rd

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (4 read ports) with a reference model and
// an expected-read queue; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned NUM_RD = 4;
  localparam int unsigned AW     = 5;

  logic                   clk;
  logic                   rst;
  logic [NUM_RD*AW-1:0]   rs_addr;
  logic [NUM_RD-1:0]      rs_en;
  logic [NUM_RD*XLEN-1:0] rv;
  logic [NUM_RD-1:0]      rs_busy;
  logic                   we;
  logic [AW-1:0]          rd;
  logic [XLEN-1:0]        indata;
  logic                   issue_en;
  logic [AW-1:0]          issue_rd;
  logic [NREGS-1:0]       busy_vec;

  regfile_sb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rs_en    (rs_en),
    .rv       (rv),
    .rs_busy  (rs_busy),
    .we       (we),
    .rd       (rd),
    .indata   (indata),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m_mem [NREGS];
  logic [31:0] m_rv  [NUM_RD];
  logic [31:0] m_busy;
  int          n_chk;
  int          n_fail;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rv_port(input int k);
    return rv[k*XLEN +: XLEN];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) m_mem[i] = '0;
    for (int k = 0; k < int'(NUM_RD); k++) m_rv[k] = '0;
    m_busy = '0;
    exp_q.delete();
  endtask

  task automatic idle();
    rs_en    = '0;
    rs_addr  = '0;
    we       = 1'b0;
    rd       = '0;
    indata   = '0;
    issue_en = 1'b0;
    issue_rd = '0;
  endtask

  task automatic set_rs(input int k, input int a);
    rs_addr[k*AW +: AW] = AW'(a);
    rs_en[k]            = 1'b1;
  endtask

  // One clock: check combinational busy, queue read expectations, advance model, compare.
  task automatic step();
    logic [4:0]  a;
    logic        eb;
    logic [31:0] e;
    exp_t        x;
    #1;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      a  = rs_addr[k*AW +: AW];
      eb = m_busy[a];
      if (BYPASS && we && (rd == a) && (a != 0) && !(issue_en && (issue_rd == a))) eb = 1'b0;
      chk_eq($sformatf("rs_busy%0d", k), 32'(rs_busy[k]), 32'(eb));
      if (rs_en[k]) begin
        if (a == 0)                              e = '0;
        else if (BYPASS && we && (rd == a))      e = indata;
        else                                     e = m_mem[a];
        m_rv[k] = e;
      end
      exp_q.push_back('{port: k, val: m_rv[k]});
    end
    if (we && (rd != 0)) begin
      m_mem[rd]  = indata;
      m_busy[rd] = 1'b0;
    end
    if (issue_en && (issue_rd != 0)) m_busy[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk_eq($sformatf("rv%0d", x.port), rv_port(x.port), x.val);
    end
    chk_eq("busy_vec", busy_vec, m_busy);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_rv0", rv_port(0), 32'h0);
    chk_eq("reset_busy", busy_vec, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-stream discards state and an in-flight issue
    idle(); we = 1'b1; rd = 5'd5; indata = 32'hDEADBEEF; issue_en = 1'b1; issue_rd = 5'd5;
    step();
    idle(); issue_en = 1'b1; issue_rd = 5'd5; set_rs(0, 5);
    step();
    chk_eq("t1_pre_rv", rv_port(0), 32'hDEADBEEF);
    idle(); issue_en = 1'b1; issue_rd = 5'd6; we = 1'b1; rd = 5'd8; indata = 32'h55;
    #2;
    rst = 1'b1;
    #1;
    chk_eq("t1_rst_busy", busy_vec, 32'h0);
    chk_eq("t1_rst_rv", rv_port(0), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(); set_rs(0, 5);
    step();
    chk_eq("t1_rv_x5", rv_port(0), 32'h0);
    chk_eq("t1_busy", busy_vec, 32'h0);

    // Write to x0 is ignored
    idle(); we = 1'b1; rd = 5'd0; indata = 32'hFFFFFFFF;
    for (int k = 0; k < int'(NUM_RD); k++) set_rs(k, 0);
    step();
    idle(); set_rs(0, 0); set_rs(1, 0);
    step();
    chk_eq("t2_rv0", rv_port(0), 32'h0);
    chk_eq("t2_rv1", rv_port(1), 32'h0);

    // Write then read next cycle
    idle(); we = 1'b1; rd = 5'd7; indata = 32'h12345678;
    step();
    idle(); set_rs(0, 7);
    step();
    chk_eq("t3_rv", rv_port(0), 32'h12345678);

    // Same-cycle read and write of one register
    idle(); we = 1'b1; rd = 5'd3; indata = 32'h11;
    step();
    idle(); we = 1'b1; rd = 5'd3; indata = 32'hA5A5A5A5; set_rs(0, 3);
    step();
    chk_eq("t4_rv_same", rv_port(0), BYPASS ? 32'hA5A5A5A5 : 32'h11);
    idle(); set_rs(0, 3);
    step();
    chk_eq("t4_rv_next", rv_port(0), 32'hA5A5A5A5);

    // Scoreboard set, set-wins, clear
    idle(); issue_en = 1'b1; issue_rd = 5'd9;
    step();
    idle(); set_rs(1, 9);
    #1;
    chk_eq("t5_rs_busy", 32'(rs_busy[1]), 32'h1);
    step();
    chk_eq("t5_set", 32'(busy_vec[9]), 32'h1);
    idle(); we = 1'b1; rd = 5'd9; indata = 32'h9; issue_en = 1'b1; issue_rd = 5'd9; set_rs(1, 9);
    step();
    chk_eq("t5_set_wins", 32'(busy_vec[9]), 32'h1);
    idle(); issue_en = 1'b1; issue_rd = 5'd10; we = 1'b1; rd = 5'd9; indata = 32'h99; set_rs(1, 9);
    #1;
    chk_eq("t5_clr_busy_c", 32'(rs_busy[1]), BYPASS ? 32'h0 : 32'h1);
    step();
    chk_eq("t5_clear", 32'(busy_vec[9]), 32'h0);
    chk_eq("t5_other_set", 32'(busy_vec[10]), 32'h1);

    // Four ports in one cycle, then hold on disabled ports
    for (int r = 1; r <= 4; r++) begin
      idle(); we = 1'b1; rd = AW'(r); indata = 32'(r);
      step();
    end
    idle();
    for (int k = 0; k < int'(NUM_RD); k++) set_rs(k, k + 1);
    step();
    for (int k = 0; k < int'(NUM_RD); k++) chk_eq($sformatf("t6_rv%0d", k), rv_port(k), 32'(k + 1));
    idle(); set_rs(0, 7); rs_addr[1*AW +: AW] = 5'd3; rs_addr[2*AW +: AW] = 5'd9;
    step();
    chk_eq("t6_hold1", rv_port(1), 32'h2);
    chk_eq("t6_hold3", rv_port(3), 32'h4);
    chk_eq("t6_new0", rv_port(0), 32'h12345678);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      idle();
      for (int k = 0; k < int'(NUM_RD); k++) begin
        rs_addr[k*AW +: AW] = AW'($urandom_range(0, 31));
        rs_en[k]            = 1'($urandom_range(0, 1));
      end
      we       = ($urandom_range(0, 2) != 0);
      rd       = AW'($urandom_range(0, 31));
      indata   = $urandom;
      issue_en = ($urandom_range(0, 1) != 0);
      issue_rd = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, 31));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_regfile_sb
